// File: rtl/reg_file_pkg.sv
// Shared constants and dump FSM state type for the RiSC-16 register file.
//   WORD_LEN     : architectural register width
//   NUM_REGS     : number of architectural registers (power of 2)
//   REG_ADDR_LEN : register index width, log2(NUM_REGS)
//   dump_state_t : debug-dump FSM states
package reg_file_pkg;

  localparam int WORD_LEN     = 16;
  localparam int NUM_REGS     = 8;
  localparam int REG_ADDR_LEN = 3;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_file_dump_ctrl.sv
// Debug-dump controller: walks the register index from 0 to NUM_REGS-1,
// presenting one beat per index over a valid/ready handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   dump_start  : one-cycle request to begin a dump (ignored unless idle)
//   dump_ready  : consumer accepts the current beat when valid && ready
//   dump_busy   : high from the cycle after dump_start until back in idle
//   dump_valid  : current beat is valid
//   dump_idx    : index of current beat; also the storage read address
module reg_dump_ctrl
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
  parameter int ADDR_LEN = reg_file_pkg::REG_ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dump_start,
  input  logic                dump_ready,
  output logic                dump_busy,
  output logic                dump_valid,
  output logic [ADDR_LEN-1:0] dump_idx
);

  localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(NUM_REGS - 1);

  dump_state_t         state, state_next;
  logic [ADDR_LEN-1:0] idx, idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DUMP_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_next = DUMP_SEND;
          idx_next   = '0;
        end
      end
      DUMP_SEND: begin
        if (dump_ready) begin
          if (idx == LAST_IDX) state_next = DUMP_DONE;
          else                 idx_next   = idx + ADDR_LEN'(1);
        end
      end
      DUMP_DONE: state_next = DUMP_IDLE;
      default:   state_next = DUMP_IDLE;
    endcase
  end

  always_comb begin
    dump_busy  = (state != DUMP_IDLE);
    dump_valid = (state == DUMP_SEND);
    // Index is only exposed during a beat so idle/done outputs read as zero.
    dump_idx   = dump_valid ? idx : '0;
  end

endmodule

// File: rtl/reg_file.sv
// RiSC-16 architectural register file: one write port, two combinational
// read ports, and a serial debug-dump port. r0 always reads as zero.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  : write-back port (WB tgt value)
//   rd_addr_a / rd_data_a  : read port A (combinational)
//   rd_addr_b / rd_data_b  : read port B (combinational)
//   dump_start             : request to stream every register
//   dump_busy/dump_valid   : dump status / beat valid
//   dump_ready             : consumer handshake
//   dump_idx/dump_data     : current beat index and value
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WORD_LEN = reg_file_pkg::WORD_LEN,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
  parameter int ADDR_LEN = reg_file_pkg::REG_ADDR_LEN,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_LEN-1:0] wr_addr,
  input  logic [WORD_LEN-1:0] wr_data,
  input  logic [ADDR_LEN-1:0] rd_addr_a,
  output logic [WORD_LEN-1:0] rd_data_a,
  input  logic [ADDR_LEN-1:0] rd_addr_b,
  output logic [WORD_LEN-1:0] rd_data_b,
  input  logic                dump_start,
  output logic                dump_busy,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [ADDR_LEN-1:0] dump_idx,
  output logic [WORD_LEN-1:0] dump_data
);

  logic [WORD_LEN-1:0] regs [NUM_REGS];

  // Read ports: 0 = A, 1 = B, 2 = dump engine.
  logic [ADDR_LEN-1:0] raddr [3];
  logic [WORD_LEN-1:0] rdata [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rdata[p] = '0;
      if (raddr[p] != '0) begin
        if ((BYPASS != 0) && wr_en && (wr_addr == raddr[p])) rdata[p] = wr_data;
        else                                                   rdata[p] = regs[raddr[p]];
      end
    end
  end

  reg_dump_ctrl #(
    .NUM_REGS (NUM_REGS),
    .ADDR_LEN (ADDR_LEN)
  ) u_dump_ctrl (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx)
  );

  assign raddr[0]  = rd_addr_a;
  assign raddr[1]  = rd_addr_b;
  assign raddr[2]  = dump_idx;
  assign rd_data_a = rdata[0];
  assign rd_data_b = rdata[1];
  // Beat data follows live storage (and bypass) until accepted.
  assign dump_data = dump_valid ? rdata[2] : '0;

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- RiSC-16 architectural register file: eight 16-bit registers; the write port consumes the write-back value `tgt` plus destination index and write enable.
- Two combinational read ports feed operand selection for the ALU and memory stages.
- A serial debug-dump engine streams all registers through a valid/ready handshake to the testbench/debug monitor without stalling the core.
- r0 reads as zero at all times.

Parameters:
- WORD_LEN, 16, register width (matches `WORD_LEN in defines.v).
- NUM_REGS, 8, number of architectural registers (power of 2).
- ADDR_LEN, 3, register index width; must equal log2(NUM_REGS).
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe from write-back control.
- wr_addr  in  ADDR_LEN  destination register index.
- wr_data  in  WORD_LEN  write-back value (WB `tgt`).
- rd_addr_a  in  ADDR_LEN  read port A index.
- rd_data_a  out  WORD_LEN  read port A data, combinational.
- rd_addr_b  in  ADDR_LEN  read port B index.
- rd_data_b  out  WORD_LEN  read port B data, combinational.
- dump_start  in  1  one-cycle request to stream all registers.
- dump_busy  out  1  high while a dump is in progress.
- dump_valid  out  1  dump_idx/dump_data hold a valid beat.
- dump_ready  in  1  consumer accepts a beat when valid&&ready.
- dump_idx  out  ADDR_LEN  index of the current beat.
- dump_data  out  WORD_LEN  value of the current beat.

Behaviour:
- Reset (asynchronous, active-high): all registers are 0, FSM is IDLE, dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0. Reset asserted mid-dump aborts the dump immediately; no further beats are issued.
- Write:
  - On a rising edge with wr_en=1 and wr_addr!=0, regs[wr_addr] takes wr_data.
  - Writes to r0 are discarded.
  - wr_en=0 leaves every register unchanged.
- Read:
  - rd_data_x = 0 if rd_addr_x==0; otherwise regs[rd_addr_x].
  - If BYPASS=1, wr_en=1, wr_addr==rd_addr_x and rd_addr_x!=0, then rd_data_x = wr_data in the same cycle.
  - If BYPASS=0, the new value is visible the cycle after the write.
  - Ports A and B may address the same register.
- Dump FSM states are IDLE, SEND, DONE.
  - IDLE: when dump_start=1, go to SEND with idx=0 and dump_busy=1. dump_start in any other state is ignored.
  - SEND: dump_valid=1, dump_idx=idx, and dump_data equals the read-port value of idx (r0 gives 0).
    - dump_data tracks writes until the beat is accepted; it is registered-stable only while no write targets idx.
    - On valid&&ready: if idx==NUM_REGS-1, go to DONE; otherwise idx increments (no wrap).
    - If ready=0, hold idx; valid stays high.
  - DONE: one cycle with dump_valid=0 and dump_busy=1, then IDLE with dump_busy=0.
- Throughput: one beat per cycle when ready is held high.
- Latency: first beat valid the cycle after dump_start; last handshake at cycle NUM_REGS.
- Writes during a dump proceed normally; a beat not yet accepted reflects the latest value, including bypass when BYPASS=1.

Decomposition:
- Shared constants go in defines.v: `WORD_LEN, `REG_ADDR_LEN, `NUM_REGS, and dump FSM state encodings `DUMP_IDLE, `DUMP_SEND, `DUMP_DONE (2-bit).
- One natural sub-module: reg_dump_ctrl (FSM + index counter + handshake). It drives a third internal read address into reg_file's storage.

Test Plan:
- Reset then reads → rst pulsed mid-run; every rd_addr 0..7 → rd_data_a/b=0; dump outputs 0.
- Write/read → wr_en=1, wr_addr=3, wr_data=16'hBEEF; next cycle rd_addr_a=3 → 16'hBEEF. Also wr_addr=0, wr_data=16'h1234 → rd_addr_b=0 reads 0.
- Bypass → BYPASS=1, regs[5]=16'h0001; same cycle wr 5←16'hAAAA with rd_addr_a=5 → rd_data_a=16'hAAAA. With BYPASS=0 → 16'h0001, then 16'hAAAA next cycle.
- Full dump with ready=1 → regs[i]=16'h1000+i for i=1..7; pulse dump_start → 8 consecutive beats idx 0..7. Data 0, 16'h1001…16'h1007. busy drops 2 cycles after the last beat.
- Backpressure → ready=0 for 3 cycles at idx=4 → idx/data held, valid high. A write of 16'h5555 to r4 during the stall → the accepted beat carries 16'h5555.
- Reset mid-dump → assert rst at idx=2 → valid/busy=0 asynchronously. A new dump_start after reset restarts at idx=0.
